mem_responder: RTL



---
 rtl/mem_resp_pkg.sv | 13 +
 rtl/mem_resp_array.sv | 24 ++
 rtl/mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the mem_responder block
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [15:0] ERR_DATA        = 16'hDEAD;
  localparam int          MAX_WAIT_STATES = 15;

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - single-port synchronous word RAM with registered read data
module mem_resp_array #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rdata_q;

  // No reset on storage or read register, so a vendor macro can drop in here.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory target with wait states
// Optional out-of-range error reporting: define MEM_RESP_ERR_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int AW          = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [15:0] mem_wdata_i,
  output logic [15:0] data_o,
  output logic        rvalid_o,
  output logic        busy_o
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam int CW      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic          wr_q, oor_q, rd_err_q;
  logic          rvalid_q, busy_q, err_q;
  logic [15:0]   data_q;

  logic          req_valid, req_oor, last_wait;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata, ram_rdata;

`ifdef MEM_RESP_ERR_EN
  assign req_oor = |mem_addr_i[31:AW];
  assign err_o   = err_q;
`else
  logic unused_bits;
  assign req_oor     = 1'b0;
  assign unused_bits = ^{mem_addr_i[31:AW], err_q};
`endif

  assign req_valid = (state_q != WAIT) && (mem_re_i || mem_we_i);
  assign last_wait = (state_q == WAIT) && (cnt_q == '0);

  // Zero wait states hit the RAM on the accepting edge; otherwise on the last WAIT edge.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = mem_addr_i[AW-1:0];
    ram_wdata = mem_wdata_i;
    if (NO_WAIT) begin
      ram_we = !rst_i && req_valid && mem_we_i && !req_oor;
      ram_re = !rst_i && req_valid && !mem_we_i && !req_oor;
    end else begin
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      ram_we    = !rst_i && last_wait && wr_q && !oor_q;
      ram_re    = !rst_i && last_wait && !wr_q && !oor_q;
    end
  end

  mem_resp_array #(.AW(AW)) u_array (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
      rd_err_q <= 1'b0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      if (rvalid_q) data_q <= data_o;
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            err_q <= oor_q;
            if (wr_q) begin
              state_q <= IDLE;
            end else begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rd_err_q <= oor_q;
            end
          end else begin
            cnt_q  <= cnt_q - CW'(1);
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          if (req_valid) begin
            addr_q  <= mem_addr_i[AW-1:0];
            wdata_q <= mem_wdata_i;
            wr_q    <= mem_we_i;
            oor_q   <= req_oor;
            if (NO_WAIT) begin
              err_q <= req_oor;
              if (!mem_we_i) begin
                state_q  <= RESP;
                rvalid_q <= 1'b1;
                rd_err_q <= req_oor;
              end
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_LOAD;
              busy_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Read data is live in the rvalid cycle and held from a register afterwards.
  assign data_o   = rvalid_q ? (rd_err_q ? ERR_DATA : ram_rdata) : data_q;
  assign rvalid_o = rvalid_q;
  assign busy_o   = busy_q;

endmodule
